// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
//
// Purpose:
//   Encodes RV32I load (I-type), store (S-type) and branch (B-type)
//   instructions from separate register/funct3/immediate fields. The encoding
//   and the immediate range check are purely combinational on the request
//   inputs. The result (instruction word + error flag) is captured into a
//   2-entry FIFO on the accepting edge and drained by the consumer. Errored
//   requests (out-of-range immediate, odd branch offset, reserved format)
//   produce a NOP word with out_err set and bump a saturating error counter.
//
// Handshakes (both sides use strict valid/ready semantics):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds its payload stable while valid=1 and ready=0. in_ready
//   depends only on registered occupancy (and reset), never on out_ready, so
//   a push is refused at occupancy 2 even when a pop happens on that edge.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state
//   in_valid   in   1   request carries a field set to encode
//   in_ready   out  1   encoder can accept a request this cycle
//   fmt        in   2   0=load, 1=store, 2=branch, 3=reserved
//   rd         in   5   destination register (load only)
//   rs1        in   5   base / first source register
//   rs2        in   5   second source register (store/branch only)
//   funct3     in   3   passed through unchanged
//   imm        in  32   signed byte offset, two's complement
//   out_valid  out  1   out_instr/out_err hold a buffered result
//   out_ready  in   1   consumer takes the head result
//   out_instr  out 32   encoded instruction word (0 when empty)
//   out_err    out  1   head result failed the range/format check
//   err_count  out  8   saturating count of accepted errored requests
// -----------------------------------------------------------------------------
module instruction_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    localparam logic [1:0]  FMT_LOAD   = 2'd0;
    localparam logic [1:0]  FMT_STORE  = 2'd1;
    localparam logic [1:0]  FMT_BRANCH = 2'd2;

    // ------------------------------------------------------------------
    // Combinational encode and range check
    // ------------------------------------------------------------------
    logic        w_fits12;
    logic        w_fits13;
    logic [31:0] w_instr;
    logic        w_err;

    // A value fits in N signed bits when all bits from N-1 upward are equal
    // (pure sign extension). 12 bits -> [-2048, 2047]; 13 bits -> [-4096,
    // 4095], and the even-offset rule trims the branch top to 4094.
    assign w_fits12 = (&imm[31:11]) | (~|imm[31:11]);
    assign w_fits13 = (&imm[31:12]) | (~|imm[31:12]);

    always_comb begin
        w_instr = INSTR_NOP;
        w_err   = 1'b1;
        case (fmt)
            FMT_LOAD: begin
                if (w_fits12) begin
                    w_instr = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                    w_err   = 1'b0;
                end
            end
            FMT_STORE: begin
                if (w_fits12) begin
                    w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                    w_err   = 1'b0;
                end
            end
            FMT_BRANCH: begin
                if (w_fits13 && !imm[0]) begin
                    w_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], OP_BRANCH};
                    w_err   = 1'b0;
                end
            end
            default: begin
                w_instr = INSTR_NOP;
                w_err   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry result FIFO
    // ------------------------------------------------------------------
    logic [32:0] r_mem [0:1];   // {err, instr}
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic [7:0]  r_err_count;

    logic        w_push;
    logic        w_pop;

    // Gating with reset keeps in_ready low for the whole reset pulse even
    // though the asynchronous clear already forces occupancy to zero.
    assign in_ready  = ~reset & (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    assign out_instr = out_valid ? r_mem[r_rptr][31:0] : 32'h0;
    assign out_err   = out_valid ? r_mem[r_rptr][32]   : 1'b0;
    assign err_count = r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= 33'h0;
            r_mem[1] <= 33'h0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {w_err, w_instr};
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (w_push && w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

endmodule
